// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS-style HI/LO multiply/divide unit.
// Operands are made positive on accept and run through WIDTH shift-add or
// restoring shift-subtract steps. Signs are reapplied in FIX. The HI/LO
// registers load on the FIX->DONE edge, so new results are visible in the
// same cycle that done pulses.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;

  // Captured operation attributes and iteration datapath.
  logic             div_mode;
  logic             res_neg;
  logic             rem_neg;
  logic             div0;
  logic [WIDTH-1:0] opd;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc;   // product upper half or partial remainder
  logic [WIDTH-1:0] quo;   // multiplier bits shifting out / quotient shifting in
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    signed_op;
  logic                    a_neg;
  logic                    b_neg;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic             sub_ok;
  logic [WIDTH-1:0] sub_diff;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Two's-complement negate when neg is set (also serves as abs on signed input).
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? WIDTH'(-v) : v;
  endfunction

  // Double-width variant for the full product.
  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (2*WIDTH)'(-v) : v;
  endfunction

  assign a_s       = bus.a;
  assign b_s       = bus.b;
  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & a_s[WIDTH-1];
  assign b_neg     = signed_op & b_s[WIDTH-1];

  assign bus.busy = (state == RUN) || (state == FIX);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: flush only cancels work in RUN/FIX; start only counts in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        if (bus.flush)                    state_next = IDLE;
        else if (cnt == CNT_W'(WIDTH-1))  state_next = FIX;
      end
      FIX:  state_next = bus.flush ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Iteration counter: held at zero outside RUN.
  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (state == RUN) cnt <= cnt + 1'b1;
    else                   cnt <= '0;
  end

  // One multiply or divide step, plus the sign-corrected final result.
  always_comb begin
    add_sum  = {1'b0, acc} + {1'b0, (quo[0] ? opd : '0)};
    shifted  = {acc, quo[WIDTH-1]};
    sub_ok   = (shifted >= {1'b0, opd});
    sub_diff = shifted[WIDTH-1:0] - opd;
    res_hi   = '0;
    res_lo   = '0;
    if (div_mode) begin
      res_hi = cond_neg(acc, rem_neg);
      res_lo = div0 ? '1 : cond_neg(quo, res_neg);
    end else begin
      {res_hi, res_lo} = cond_neg2({acc, quo}, res_neg);
    end
  end

  // Operand capture on accept and per-cycle iteration in RUN.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      div_mode <= bus.op[1];
      res_neg  <= a_neg ^ b_neg;
      rem_neg  <= a_neg;
      div0     <= (bus.b == '0);
      acc      <= '0;
      if (bus.op[1]) begin
        opd <= cond_neg(bus.b, b_neg);
        quo <= cond_neg(bus.a, a_neg);
      end else begin
        opd <= cond_neg(bus.a, a_neg);
        quo <= cond_neg(bus.b, b_neg);
      end
    end else if (state == RUN) begin
      if (div_mode) begin
        acc <= sub_ok ? sub_diff : shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], sub_ok};
      end else begin
        acc <= add_sum[WIDTH:1];
        quo <= {add_sum[0], quo[WIDTH-1:1]};
      end
    end
  end

  // HI/LO load leaving FIX unless the operation is being flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (state == FIX && !bus.flush) begin
      hi_r <= res_hi;
      lo_r <= res_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: signed/unsigned multiply and divide,
// divide-by-zero, overflow, flush, ignored start and mid-operation reset.
module tb_muldiv_ctrl;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op in the current cycle (cycle 0) and follow it to cycle 35.
  // With intrude set, a different start is driven in cycles 5-6.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi,
                        input logic [31:0] elo, input bit intrude);
    int nbusy;
    int ndone;
    nbusy = 0;
    ndone = 0;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    chk1({tag, "_c0_busy"}, bus.busy, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      step();
      bus.flush = 1'b0;
      bus.a     = ~x;
      bus.b     = ~y;
      if (intrude && (k == 5)) begin
        bus.start = 1'b1;
        bus.op    = DIVU;
      end else begin
        bus.start = 1'b0;
        bus.op    = o;
      end
      if (bus.busy) nbusy++;
      if (bus.done) ndone++;
    end
    chk32({tag, "_busy_cycles"}, 32'(nbusy), 32'd33);
    chk32({tag, "_early_done"}, 32'(ndone), 32'd0);
    step();
    chk1({tag, "_c34_done"}, bus.done, 1'b1);
    chk1({tag, "_c34_busy"}, bus.busy, 1'b0);
    chk32({tag, "_hi"}, bus.hi, ehi);
    chk32({tag, "_lo"}, bus.lo, elo);
    step();
    chk1({tag, "_c35_done"}, bus.done, 1'b0);
    chk32({tag, "_hi_hold"}, bus.hi, ehi);
  endtask

  initial begin
    int ndone;
    bus.start = 1'b0;
    bus.op    = MULTU;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;

    // Reset state
    step();
    step();
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk32("rst_hi", bus.hi, 32'h0);
    chk32("rst_lo", bus.lo, 32'h0);
    rst = 1'b0;
    step();

    // Arithmetic cases
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div_neg_a", DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_neg_b", DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_zero", DIVU,  32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_rem",  DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);

    // Flush in RUN at cycle 10: cancelled, HI/LO keep 2 / 14
    bus.start = 1'b1;
    bus.op    = MULTU;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      step();
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk1("flush_c11_busy", bus.busy, 1'b0);
    chk1("flush_c11_done", bus.done, 1'b0);
    chk32("flush_hi_keep", bus.hi, 32'd2);
    chk32("flush_lo_keep", bus.lo, 32'd14);
    step();
    chk1("flush_c12_done", bus.done, 1'b0);
    // Restart at cycle 12 with flush also high: start wins in IDLE
    bus.flush = 1'b1;
    run_op("after_flush", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    // Flush in FIX (cycle 33): no write, no done
    bus.start = 1'b1;
    bus.op    = MULTU;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    for (int k = 1; k <= 33; k++) begin
      step();
      bus.start = 1'b0;
    end
    chk1("fix_busy", bus.busy, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk1("fixflush_done", bus.done, 1'b0);
    chk1("fixflush_busy", bus.busy, 1'b0);
    chk32("fixflush_lo", bus.lo, 32'd42);

    // Start while busy is ignored
    run_op("ignore_start", MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 1'b1);

    // Reset at cycle 20 mid-operation
    bus.start = 1'b1;
    bus.op    = MULTU;
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    for (int k = 1; k <= 20; k++) begin
      step();
      bus.start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_done", bus.done, 1'b0);
    chk32("midrst_hi", bus.hi, 32'h0);
    chk32("midrst_lo", bus.lo, 32'h0);
    ndone = 0;
    for (int k = 22; k <= 36; k++) begin
      step();
      if (bus.done) ndone++;
    end
    chk32("midrst_no_done", 32'(ndone), 32'd0);

    // Reset has priority over start
    rst       = 1'b1;
    bus.start = 1'b1;
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    step();
    chk1("rst_over_start", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; iteration count equals WIDTH.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
REQ-006 SHALL have port a  input  WIDTH  multiplicand/dividend, captured on accept.
REQ-007 SHALL have port b  input  WIDTH  multiplier/divisor, captured on accept.
REQ-008 SHALL have port flush  input  1  cancel the in-flight operation (pipeline exception/flush).
REQ-009 SHALL have port busy  output  1  high while an operation is in RUN or FIX; the pipeline stalls mfhi/mflo/new muldiv on it.
REQ-010 SHALL have port done  output  1  one-cycle pulse when hi/lo are updated.
REQ-011 SHALL have port hi  output  WIDTH  HI register (product upper half / remainder).
REQ-012 SHALL have port lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-014 IDLE with start=1 SHALL accept: latch op, take absolute values of a and b for MULT/DIV (raw for MULTU/DIVU), record result signs, clear iteration counter, go to RUN.
REQ-015 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle for exactly WIDTH cycles, counter 0..WIDTH-1, then go to FIX.
REQ-016 FIX SHALL apply sign correction: product negated if signs of a and b differ; quotient negated if signs differ; remainder takes sign of a; then go to DONE.
REQ-017 DONE SHALL write hi/lo, assert done for exactly that cycle, and return to IDLE the next cycle.
REQ-018 Latency SHALL be fixed: accept in cycle 0, done high in cycle WIDTH+2 (34 for WIDTH=32), independent of operand values.
REQ-019 busy SHALL be high from the cycle after accept through FIX inclusive, and low in IDLE and DONE.
REQ-020 start while not in IDLE SHALL be ignored with no effect on the running operation.
REQ-021 Divide by zero (b==0, DIV or DIVU) SHALL complete with the same latency and write hi=a, lo={WIDTH{1'b1}}.
REQ-022 DIV of most-negative value by -1 SHALL write lo=most-negative value, hi=0.
REQ-023 Multiply SHALL produce the full 2*WIDTH-bit product, upper half to hi, lower half to lo.
REQ-024 flush in RUN or FIX SHALL return the FSM to IDLE on the next edge, leave hi/lo unchanged and suppress done; flush in IDLE or DONE SHALL have no effect (DONE write still completes).
REQ-025 flush and start in the same IDLE cycle SHALL result in the start being accepted.
REQ-026 hi/lo SHALL change only in DONE or on reset.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, in any state including mid-operation.
REQ-028 rst SHALL take priority over start and flush in the same cycle.

Verification
REQ-029 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> done at cycle 34, hi=32'hFFFFFFFE, lo=32'h00000001, busy high cycles 1-33.
REQ-030 MULT a=-3, b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-031 DIVU a=32'h00001234, b=0 -> done at cycle 34, hi=32'h00001234, lo=32'hFFFFFFFF; DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
REQ-032 Start MULTU 6*7, assert flush at cycle 10 -> busy low from cycle 11, no done pulse, hi/lo keep prior values; new start at cycle 12 accepted and completes normally (lo=42).
REQ-033 Start new op at cycle 5 while busy -> ignored, original result delivered at cycle 34; rst at cycle 20 -> IDLE, hi=lo=0, no done.
